// File: rtl/vc_rand_delay_pkg.sv
// Shared types and constants for the random-delay val/rdy stage and its LFSR.
package vc_rand_delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SEND  = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam int unsigned MSG_SZ_DFLT = 67;

  // Right-shifting Galois step: the bit shifted out selects the tap XOR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    lfsr_next = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/vc_lfsr32.sv
// 32-bit Galois LFSR with synchronous active-low reset to a seed (0 forced to 1).
module vc_lfsr32
  import vc_rand_delay_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] seed,
  output logic [31:0] out
);

  logic [31:0] lfsr_q;
  logic [31:0] seed_s;

  // An all-zero state would lock the LFSR, so seed 0 behaves as seed 1.
  assign seed_s = (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;

  // LFSR state register, stepped only when enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= seed_s;
    end else if (en) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/vc_rand_delay_stage.sv
// Single-entry val/rdy buffer that holds each message for an LFSR-chosen delay.
// Define VC_RAND_DELAY_STATS_EN to add hierarchically-readable statistics counters.
module vc_rand_delay_stage
  import vc_rand_delay_pkg::*;
#(
  parameter int unsigned p_msg_sz    = MSG_SZ_DFLT,
  parameter int unsigned p_max_delay = 4,
  parameter logic [31:0] p_seed      = 32'hB1A5_F00D
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [p_msg_sz-1:0] in_msg,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [p_msg_sz-1:0] out_msg
);

  localparam int unsigned CNT_W = (p_max_delay == 0) ? 1 : $clog2(p_max_delay + 1);
  localparam int unsigned NUM_D = p_max_delay + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [p_msg_sz-1:0] buf_q, buf_d;
  logic [31:0]         lfsr_s;
  logic [CNT_W-1:0]    draw_s;
  logic                accept_s;
  logic                lfsr_unused_s;

  // out_rdy feeds in_rdy combinationally so a departing message frees the slot in the same cycle.
  assign in_rdy   = reset & ((state_q == IDLE) | ((state_q == SEND) & out_rdy));
  assign accept_s = in_val & in_rdy;

  vc_lfsr32 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (accept_s),
    .seed  (p_seed),
    .out   (lfsr_s)
  );

  assign draw_s        = CNT_W'(32'(lfsr_s[15:0]) % NUM_D);
  assign lfsr_unused_s = ^lfsr_s[31:16];

  // Next-state logic: an accept always reloads the buffer and the delay.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    if (accept_s) begin
      buf_d = in_msg;
      if (draw_s == '0) begin
        state_d = SEND;
        cnt_d   = '0;
      end else begin
        state_d = DELAY;
        cnt_d   = draw_s;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        DELAY: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = SEND;
          end else begin
            state_d = DELAY;
          end
        end
        SEND: begin
          if (out_rdy) begin
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, countdown and message buffer registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign out_val = (state_q == SEND);
  assign out_msg = buf_q;

`ifdef VC_RAND_DELAY_STATS_EN
  logic [31:0] num_msgs;
  logic [31:0] num_delay_cycles;
  logic [31:0] num_stall_cycles;

  // Statistics counters for the simulation harness.
  always_ff @(posedge clk) begin
    if (!reset) begin
      num_msgs         <= 32'd0;
      num_delay_cycles <= 32'd0;
      num_stall_cycles <= 32'd0;
    end else begin
      if (accept_s) begin
        num_msgs <= num_msgs + 32'd1;
      end
      if (state_q == DELAY) begin
        num_delay_cycles <= num_delay_cycles + 32'd1;
      end
      if ((state_q == SEND) && !out_rdy) begin
        num_stall_cycles <= num_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vc_rand_delay_stage.sv
// Randomized bench: three stage instances checked cycle-by-cycle against a timestamp model.
module tb_vc_rand_delay_stage;

  logic               clk;
  logic [2:0]         rst_n;
  logic [2:0]         in_val;
  logic [2:0]         in_rdy_w;
  logic [2:0][66:0]   in_msg;
  logic [2:0]         out_val_w;
  logic [2:0]         out_rdy;
  logic [2:0][66:0]   out_msg_w;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  bit          pend[3];
  logic [66:0] pmsg[3];
  int          rdy_cyc[3];
  logic [31:0] mlfsr[3];
  bit          waitd[3];
  int          acc_cyc[3];
  int          exp_d[3];
  int          accepts[3];
  int          accepts_rst[3];
  int          hist[5];

  vc_rand_delay_stage #(.p_msg_sz(67), .p_max_delay(0)) u_d0 (
    .clk(clk), .reset(rst_n[0]), .in_val(in_val[0]), .in_rdy(in_rdy_w[0]), .in_msg(in_msg[0]),
    .out_val(out_val_w[0]), .out_rdy(out_rdy[0]), .out_msg(out_msg_w[0]));
  vc_rand_delay_stage #(.p_msg_sz(67), .p_max_delay(4), .p_seed(32'h0000_1234)) u_d1 (
    .clk(clk), .reset(rst_n[1]), .in_val(in_val[1]), .in_rdy(in_rdy_w[1]), .in_msg(in_msg[1]),
    .out_val(out_val_w[1]), .out_rdy(out_rdy[1]), .out_msg(out_msg_w[1]));
  vc_rand_delay_stage #(.p_msg_sz(67), .p_max_delay(4), .p_seed(32'h0000_0000)) u_d2 (
    .clk(clk), .reset(rst_n[2]), .in_val(in_val[2]), .in_rdy(in_rdy_w[2]), .in_msg(in_msg[2]),
    .out_val(out_val_w[2]), .out_rdy(out_rdy[2]), .out_msg(out_msg_w[2]));

  always #5 clk = ~clk;

  function automatic int max_of(input int k);
    return (k == 0) ? 0 : 4;
  endfunction

  // Instance 2 is built with seed 0, which must behave exactly like seed 1.
  function automatic logic [31:0] seed_of(input int k);
    return (k == 0) ? 32'hB1A5_F00D : ((k == 1) ? 32'h0000_1234 : 32'h0000_0001);
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    logic [31:0] nx;
    nx = cur >> 1;
    if (cur[0]) nx = nx ^ 32'h8020_0003;
    return nx;
  endfunction

  task automatic check_eq(input string tag, input logic [66:0] got, input logic [66:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Expected behaviour: a message accepted at cycle t with draw d is presented from t+1+d until taken.
  task automatic model_cycle(input int k);
    bit exp_val, exp_rdy, fire, acc;
    int d, obs;
    exp_val = pend[k] && (cyc >= rdy_cyc[k]);
    exp_rdy = rst_n[k] && (!pend[k] || (exp_val && out_rdy[k]));
    check_eq($sformatf("out_val%0d", k), out_val_w[k], exp_val);
    check_eq($sformatf("in_rdy%0d", k), in_rdy_w[k], exp_rdy);
    check_eq($sformatf("out_msg%0d", k), out_msg_w[k], pmsg[k]);
    if (rst_n[k] && waitd[k] && out_val_w[k]) begin
      obs = cyc - acc_cyc[k] - 1;
      check_eq($sformatf("delay%0d", k), obs, exp_d[k]);
      if (k == 1 && obs >= 0 && obs <= 4) hist[obs]++;
      waitd[k] = 1'b0;
    end
    fire = exp_val && out_rdy[k];
    acc  = in_val[k] && exp_rdy;
    if (!rst_n[k]) begin
      pend[k] = 1'b0; pmsg[k] = '0; mlfsr[k] = seed_of(k); waitd[k] = 1'b0; accepts_rst[k] = 0;
    end else begin
      if (fire) pend[k] = 1'b0;
      if (acc) begin
        d           = int'(mlfsr[k][15:0]) % (max_of(k) + 1);
        mlfsr[k]    = lfsr_step(mlfsr[k]);
        pend[k]     = 1'b1;
        pmsg[k]     = in_msg[k];
        rdy_cyc[k]  = cyc + 1 + d;
        exp_d[k]    = d;
        waitd[k]    = 1'b1;
        acc_cyc[k]  = cyc;
        accepts[k]++;
        accepts_rst[k]++;
      end
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic run_cycle();
    #1;
    for (int k = 0; k < 3; k++) model_cycle(k);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive_rand(input int k, input int pv, input int pr);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    in_val[k]  = ($urandom_range(99) < pv);
    in_msg[k]  = r[66:0];
    out_rdy[k] = ($urandom_range(99) < pr);
  endtask

  initial begin
    int guard;
    bit found;
    clk = 1'b0; rst_n = 3'b000; in_val = 3'b000; out_rdy = 3'b000; in_msg = '0;
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b0; pmsg[k] = '0; mlfsr[k] = seed_of(k); waitd[k] = 1'b0;
      rdy_cyc[k] = 0; acc_cyc[k] = 0; exp_d[k] = 0; accepts[k] = 0; accepts_rst[k] = 0;
    end
    for (int i = 0; i < 5; i++) hist[i] = 0;
    repeat (2) @(negedge clk);

    run_cycle();
    check_eq("lfsr_seed1234", u_d1.u_lfsr.out, 32'h0000_1234);
    check_eq("lfsr_seed0", u_d2.u_lfsr.out, 32'h0000_0001);
    rst_n = 3'b111;
    run_cycle();

    // Zero-delay instance: back-to-back messages with no bubble.
    out_rdy[0] = 1'b1; in_val[0] = 1'b1;
    in_msg[0] = {1'b1, 32'h0000_1000, 2'b00, 32'hDEAD_BEEF};
    run_cycle();
    in_msg[0] = {1'b0, 32'h0000_1004, 2'b00, 32'h0000_0000};
    run_cycle();
    in_val[0] = 1'b0;
    repeat (2) run_cycle();

    // Five cycles of backpressure with a new message waiting.
    in_val[0] = 1'b1; in_msg[0] = {1'b1, 32'hCAFE_0000, 2'b01, 32'h1234_5678}; out_rdy[0] = 1'b0;
    run_cycle();
    in_msg[0] = {1'b0, 32'h0BAD_F00D, 2'b10, 32'h8765_4321};
    repeat (5) run_cycle();
    out_rdy[0] = 1'b1; in_val[0] = 1'b0;
    repeat (2) run_cycle();

    guard = 0;
    while (accepts[1] < 400 && guard < 15000) begin
      drive_rand(0, 60, 80); drive_rand(1, 70, 50); drive_rand(2, 70, 70);
      run_cycle();
      guard++;
    end
    check_eq("phaseA_done", (accepts[1] >= 400), 1'b1);

    // Reset instance 1 while it is counting down.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      drive_rand(0, 60, 80); drive_rand(1, 70, 50); drive_rand(2, 70, 70);
      if (pend[1] && (cyc < rdy_cyc[1])) found = 1'b1;
      else run_cycle();
    end
    check_eq("reset_in_delay_found", found, 1'b1);
    rst_n[1] = 1'b0;
    run_cycle();
    drive_rand(1, 70, 50);
    run_cycle();
    check_eq("lfsr_after_reset", u_d1.u_lfsr.out, 32'h0000_1234);
    rst_n[1] = 1'b1;

    guard = 0;
    while (accepts[1] < 1000 && guard < 15000) begin
      drive_rand(0, 60, 80); drive_rand(1, 70, 90); drive_rand(2, 70, 70);
      run_cycle();
      guard++;
    end
    check_eq("phaseB_done", (accepts[1] >= 1000), 1'b1);

    in_val = 3'b000; out_rdy = 3'b111;
    repeat (10) run_cycle();
    for (int i = 0; i < 5; i++) check_eq($sformatf("delay_%0d_seen", i), (hist[i] > 0), 1'b1);
`ifdef VC_RAND_DELAY_STATS_EN
    check_eq("num_msgs", u_d1.num_msgs, accepts_rst[1]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
